simon_iter_core: RTL and testbench

// Parametrised iterative SIMON control + datapath. Generalises SIMON_control to any SIMON (N, M, T, z) config with enc/dec mode.

---
 rtl/simon_iter_core_pkg.sv | 48 ++++
 rtl/simon_iter_core_if.sv | 30 +++
 rtl/simon_iter_core_round.sv | 16 +
 rtl/simon_iter_core.sv | 156 +++++++++++++++
 tb/tb_simon_iter_core.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_iter_core_pkg.sv
// Shared constants and word helpers for the iterative SIMON core.
// All helpers work on 64-bit containers and mask down to the live word width nb.
package simon_iter_core_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_KEYEXP = 3'd1;
    localparam state_t S_READY  = 3'd2;
    localparam state_t S_RUN    = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    // z[i] lives at bit 61-i, so the literals read left to right as published
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    function automatic logic [63:0] word_mask(input int nb);
        return (nb >= 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << nb) - 64'd1);
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] w, input int n, input int nb);
        return ((w << n) | (w >> (nb - n))) & word_mask(nb);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] w, input int n, input int nb);
        return ((w >> n) | (w << (nb - n))) & word_mask(nb);
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] w, input int nb);
        return (rol(w, 1, nb) & rol(w, 8, nb)) ^ rol(w, 2, nb);
    endfunction

    function automatic logic zbit(input int s, input int i);
        logic [61:0] z;
        case (s)
            0:       z = Z0;
            1:       z = Z1;
            2:       z = Z2;
            3:       z = Z3;
            default: z = Z4;
        endcase
        return z[6'(61 - (i % 62))];
    endfunction

endpackage

// File: rtl/simon_iter_core_if.sv
// Host-side load/read handshake and result bus of the SIMON core.
interface simon_iter_core_if #(
    parameter int N = 16,
    parameter int M = 4
);
    logic                newKEY;
    logic [M-1:0][N-1:0] KEY;
    logic                newDATA;
    logic                decrypt;
    logic [1:0][N-1:0]   inDATA;
    logic [7:0]          infoIN;
    logic                readDATA;
    logic                loadKEY;
    logic                loadDATA;
    logic                doneKEY;
    logic                doneDATA;
    logic [1:0][N-1:0]   outDATA;
    logic [7:0]          infoOUT;
    logic [7:0]          countOUT;

    modport master (
        output newKEY, KEY, newDATA, decrypt, inDATA, infoIN, readDATA,
        input  loadKEY, loadDATA, doneKEY, doneDATA, outDATA, infoOUT, countOUT
    );

    modport slave (
        input  newKEY, KEY, newDATA, decrypt, inDATA, infoIN, readDATA,
        output loadKEY, loadDATA, doneKEY, doneDATA, outDATA, infoOUT, countOUT
    );
endinterface

// File: rtl/simon_iter_core_round.sv
// One combinational SIMON round on (a, b): a' = b ^ f(a) ^ k, b' = a.
// Decryption reuses it by presenting the words swapped.
module simon_iter_core_round
    import simon_iter_core_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] k_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o
);
    assign a_o = b_i ^ N'(simon_f(64'(a_i), N)) ^ k_i;
    assign b_o = a_i;
endmodule

// File: rtl/simon_iter_core.sv
// Iterative SIMON engine: expands the round-key schedule once per key, then
// runs one round per clock for a single block in flight.
module simon_iter_core
    import simon_iter_core_pkg::*;
#(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int T    = 32,
    parameter int ZSEQ = 0
) (
    input logic              clk,
    input logic              nR,
    simon_iter_core_if.slave bus
);
    localparam int IW = $clog2(T);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N-1:0]        x_q, x_d, y_q, y_d;
    logic [7:0]          info_q, info_d;
    logic                dec_q, dec_d;
    logic                lkey_q, lkey_d, ldat_q, ldat_d;
    logic                dkey_q, dkey_d, ddat_q, ddat_d;
    logic [T-1:0][N-1:0] rk_q;

    logic          key_acc, dat_acc, ke_we;
    logic [IW-1:0] ke_idx, rd_idx;
    logic [N-1:0]  rk_new, a_in, b_in, a_out, b_out;
    logic [63:0]   t_w;
    int            zi;

    assign key_acc = bus.newKEY &&
                     (state_q == S_IDLE || state_q == S_READY || state_q == S_DONE);
    assign dat_acc = bus.newDATA && !bus.newKEY && (state_q == S_READY);
    assign ke_we   = (state_q == S_KEYEXP);
    assign ke_idx  = cnt_q[IW-1:0];

    // Next schedule word rk[idx] from the M words behind it
    always_comb begin
        zi  = (int'(cnt_q) - M) % 62;
        t_w = ror(64'(rk_q[ke_idx - IW'(1)]), 3, N);
        if (M == 4) t_w = t_w ^ 64'(rk_q[ke_idx - IW'(3)]);
        rk_new = N'(~64'(rk_q[ke_idx - IW'(M)]) ^ 64'd3 ^ 64'(zbit(ZSEQ, zi))
                    ^ t_w ^ ror(t_w, 1, N));
    end

    // Seed words load on key accept, the rest are filled one per KEYEXP cycle
    for (genvar g = 0; g < T; g++) begin : g_rk
        if (g < M) begin : g_seed
            always_ff @(posedge clk)
                if (key_acc) rk_q[g] <= bus.KEY[g];
        end else begin : g_exp
            always_ff @(posedge clk)
                if (ke_we && ke_idx == IW'(g)) rk_q[g] <= rk_new;
        end
    end

    assign rd_idx = dec_q ? (IW'(T - 1) - ke_idx) : ke_idx;
    assign a_in   = dec_q ? y_q : x_q;
    assign b_in   = dec_q ? x_q : y_q;

    simon_iter_core_round #(.N(N)) u_round (
        .a_i (a_in),
        .b_i (b_in),
        .k_i (rk_q[rd_idx]),
        .a_o (a_out),
        .b_o (b_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        info_d  = info_q;
        dec_d   = dec_q;
        lkey_d  = 1'b0;
        ldat_d  = 1'b0;
        dkey_d  = dkey_q;
        ddat_d  = ddat_q;
        case (state_q)
            S_IDLE, S_READY, S_DONE: begin
                if (key_acc) begin
                    state_d = S_KEYEXP;
                    cnt_d   = 8'(M);
                    dkey_d  = 1'b0;
                    ddat_d  = 1'b0;
                    lkey_d  = 1'b1;
                end else if (dat_acc) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    x_d     = bus.inDATA[1];
                    y_d     = bus.inDATA[0];
                    info_d  = bus.infoIN;
                    dec_d   = bus.decrypt;
                    ldat_d  = 1'b1;
                end else if (state_q == S_DONE && bus.readDATA) begin
                    state_d = S_READY;
                    ddat_d  = 1'b0;
                end
            end
            S_KEYEXP: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(T - 1)) begin
                    state_d = S_READY;
                    dkey_d  = 1'b1;
                end
            end
            S_RUN: begin
                x_d   = dec_q ? b_out : a_out;
                y_d   = dec_q ? a_out : b_out;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(T - 1)) begin
                    state_d = S_DONE;
                    ddat_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            info_q  <= '0;
            dec_q   <= 1'b0;
            lkey_q  <= 1'b0;
            ldat_q  <= 1'b0;
            dkey_q  <= 1'b0;
            ddat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            info_q  <= info_d;
            dec_q   <= dec_d;
            lkey_q  <= lkey_d;
            ldat_q  <= ldat_d;
            dkey_q  <= dkey_d;
            ddat_q  <= ddat_d;
        end
    end

    assign bus.loadKEY  = lkey_q;
    assign bus.loadDATA = ldat_q;
    assign bus.doneKEY  = dkey_q;
    assign bus.doneDATA = ddat_q;
    assign bus.outDATA  = {x_q, y_q};
    assign bus.infoOUT  = info_q;
    assign bus.countOUT = cnt_q;

endmodule

// File: tb/tb_simon_iter_core.sv
// Self-checking bench: SIMON32/64 and SIMON128/128 instances against known
// answers and a block-level reference cipher.
module tb_simon_iter_core;

    logic clk = 1'b0;
    logic nR  = 1'b0;
    always #5 clk = ~clk;

    simon_iter_core_if #(.N(16), .M(4)) h32 ();
    simon_iter_core_if #(.N(64), .M(2)) h128 ();

    simon_iter_core #(.N(16), .M(4), .T(32), .ZSEQ(0)) u32 (.clk(clk), .nR(nR), .bus(h32));
    simon_iter_core #(.N(64), .M(2), .T(68), .ZSEQ(2)) u128 (.clk(clk), .nR(nR), .bus(h128));

    localparam logic [61:0] ZS [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111};

    int n_chk  = 0;
    int n_pass = 0;
    logic [3:0][15:0] cur_key;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] w, input int n, input int nb);
        logic [63:0] msk;
        msk = (nb == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << nb) - 64'd1);
        return ((w << n) | (w >> (nb - n))) & msk;
    endfunction

    function automatic logic [63:0] rf(input logic [63:0] w, input int nb);
        return (rotl(w, 1, nb) & rotl(w, 8, nb)) ^ rotl(w, 2, nb);
    endfunction

    // Whole-block SIMON: full key schedule, then T Feistel rounds
    function automatic logic [127:0] ref_cipher(input logic [3:0][63:0] key, input int m,
        input int nb, input int t, input int zs, input logic [63:0] xi, input logic [63:0] yi,
        input bit dec);
        logic [63:0] rk [72];
        logic [63:0] msk, tmp, x, y, a;
        msk = (nb == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << nb) - 64'd1);
        x = xi;
        y = yi;
        for (int i = 0; i < m; i++) rk[i] = key[i];
        for (int i = m; i < t; i++) begin
            tmp = rotl(rk[i-1], nb - 3, nb);
            if (m == 4) tmp = tmp ^ rk[i-3];
            tmp = tmp ^ rotl(tmp, nb - 1, nb);
            rk[i] = (~rk[i-m] ^ tmp ^ 64'((ZS[zs] >> (61 - ((i - m) % 62))) & 62'd1) ^ 64'd3) & msk;
        end
        for (int r = 0; r < t; r++) begin
            if (!dec) begin
                a = x; x = y ^ rf(x, nb) ^ rk[r]; y = a;
            end else begin
                a = y; y = x ^ rf(y, nb) ^ rk[t-1-r]; x = a;
            end
        end
        return {x, y};
    endfunction

    function automatic logic [127:0] exp32(input logic [15:0] x, input logic [15:0] y, input bit dec);
        logic [3:0][63:0] k;
        for (int i = 0; i < 4; i++) k[i] = 64'(cur_key[i]);
        return ref_cipher(k, 4, 16, 32, 0, 64'(x), 64'(y), dec);
    endfunction

    function automatic logic [127:0] out32();
        return {64'(h32.outDATA[1]), 64'(h32.outDATA[0])};
    endfunction

    task automatic key32(input logic [3:0][15:0] k);
        int c;
        @(negedge clk);
        h32.newKEY = 1'b1;
        h32.KEY    = k;
        cur_key    = k;
        c = 0;
        do begin @(negedge clk); c++; end while (!h32.loadKEY && c < 8);
        h32.newKEY = 1'b0;
        chk("loadKEY", h32.loadKEY, 1);
        chk("kexp_idx0", h32.countOUT, 4);
        c = 0;
        while (!h32.doneKEY && c < 100) begin @(negedge clk); c++; end
        chk("kexp_cycles", c, 28);
    endtask

    task automatic start32(input logic [15:0] x, input logic [15:0] y, input bit dec, input logic [7:0] tag);
        int c;
        @(negedge clk);
        h32.newDATA = 1'b1;
        h32.inDATA  = {x, y};
        h32.decrypt = dec;
        h32.infoIN  = tag;
        c = 0;
        do begin @(negedge clk); c++; end while (!h32.loadDATA && c < 8);
        h32.newDATA = 1'b0;
        chk("loadDATA", h32.loadDATA, 1);
        chk("run_idx0", h32.countOUT, 0);
    endtask

    task automatic finish32(input logic [127:0] exp, input logic [7:0] tag, input int lat, input string nm);
        int c;
        c = 0;
        while (!h32.doneDATA && c < 100) begin @(negedge clk); c++; end
        chk({nm, "_lat"}, c, lat);
        chk({nm, "_out"}, out32(), exp);
        chk({nm, "_tag"}, h32.infoOUT, tag);
        h32.readDATA = 1'b1;
        @(negedge clk);
        h32.readDATA = 1'b0;
        chk({nm, "_rel"}, h32.doneDATA, 0);
    endtask

    task automatic kat128();
        int c;
        @(negedge clk);
        h128.newKEY = 1'b1;
        h128.KEY    = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
        c = 0;
        do begin @(negedge clk); c++; end while (!h128.loadKEY && c < 8);
        h128.newKEY = 1'b0;
        chk("k128_loadKEY", h128.loadKEY, 1);
        c = 0;
        while (!h128.doneKEY && c < 200) begin @(negedge clk); c++; end
        chk("k128_kexp", c, 66);
        h128.newDATA = 1'b1;
        h128.decrypt = 1'b0;
        h128.inDATA  = {64'h6373656420737265, 64'h6c6c657661727420};
        h128.infoIN  = 8'h5a;
        c = 0;
        do begin @(negedge clk); c++; end while (!h128.loadDATA && c < 8);
        h128.newDATA = 1'b0;
        chk("k128_loadDATA", h128.loadDATA, 1);
        c = 0;
        while (!h128.doneDATA && c < 200) begin @(negedge clk); c++; end
        chk("k128_lat", c, 68);
        chk("k128_ct", h128.outDATA, {64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc});
        chk("k128_tag", h128.infoOUT, 8'h5a);
    endtask

    initial begin
        logic [15:0] bx, by, bx2, by2;
        logic [7:0]  tg, tg2;
        logic [31:0] r;
        logic [63:0] kr;
        bit          bd, seen;
        int          c;

        h32.newKEY = 0;  h32.KEY = '0;  h32.newDATA = 0;  h32.decrypt = 0;
        h32.inDATA = '0; h32.infoIN = '0; h32.readDATA = 0;
        h128.newKEY = 0; h128.KEY = '0; h128.newDATA = 0; h128.decrypt = 0;
        h128.inDATA = '0; h128.infoIN = '0; h128.readDATA = 0;

        repeat (2) @(negedge clk);
        chk("rst_flags32", {h32.loadKEY, h32.loadDATA, h32.doneKEY, h32.doneDATA}, 0);
        chk("rst_bus32", {h32.outDATA, h32.infoOUT, h32.countOUT}, 0);
        chk("rst_flags128", {h128.loadKEY, h128.loadDATA, h128.doneKEY, h128.doneDATA}, 0);
        nR = 1'b1;

        kat128();

        // Published SIMON32/64 vector, both directions
        key32({16'h1918, 16'h1110, 16'h0908, 16'h0100});
        start32(16'h6565, 16'h6877, 1'b0, 8'h11);
        finish32({64'h000000000000c69b, 64'h000000000000e9bb}, 8'h11, 32, "kat_enc");
        start32(16'hc69b, 16'he9bb, 1'b1, 8'hd0);
        finish32({64'h0000000000006565, 64'h0000000000006877}, 8'hd0, 32, "kat_dec");

        // Random keys and blocks; inputs scrambled mid-run must not matter
        for (int k = 0; k < 3; k++) begin
            kr = {$urandom(), $urandom()};
            key32(kr);
            for (int b = 0; b < 3; b++) begin
                r  = $urandom();
                bx = r[31:16];
                by = r[15:0];
                bd = 1'($urandom_range(0, 1));
                tg = 8'($urandom());
                start32(bx, by, bd, tg);
                h32.decrypt = ~bd;
                h32.inDATA  = $urandom();
                h32.infoIN  = ~tg;
                finish32(exp32(bx, by, bd), tg, 32, "rnd");
            end
        end

        // newKEY during RUN is ignored
        r = $urandom();
        bx = r[31:16]; by = r[15:0]; tg = 8'h3c;
        start32(bx, by, 1'b0, tg);
        h32.newKEY = 1'b1;
        h32.KEY    = ~cur_key;
        seen = 0;
        repeat (5) begin @(negedge clk); seen |= h32.loadKEY; end
        h32.newKEY = 1'b0;
        chk("no_loadKEY_run", seen, 0);
        finish32(exp32(bx, by, 1'b0), tg, 27, "keyrun");

        // newDATA held through RUN and DONE; accepted only after readDATA
        r = $urandom();
        bx = r[31:16]; by = r[15:0]; tg = 8'h77;
        r = $urandom();
        bx2 = r[31:16]; by2 = r[15:0]; tg2 = 8'h99;
        start32(bx, by, 1'b0, tg);
        h32.newDATA = 1'b1;
        h32.inDATA  = {bx2, by2};
        h32.decrypt = 1'b1;
        h32.infoIN  = tg2;
        seen = 0;
        c = 0;
        while (!h32.doneDATA && c < 100) begin @(negedge clk); c++; seen |= h32.loadDATA; end
        chk("hold_lat", c, 32);
        chk("hold_out", out32(), exp32(bx, by, 1'b0));
        repeat (3) begin @(negedge clk); seen |= h32.loadDATA; end
        chk("no_loadDATA_run_done", seen, 0);
        chk("done_stable_out", out32(), exp32(bx, by, 1'b0));
        chk("done_stable_tag", h32.infoOUT, tg);
        h32.readDATA = 1'b1;
        @(negedge clk);
        h32.readDATA = 1'b0;
        chk("read_done_drop", h32.doneDATA, 0);
        chk("read_no_load_yet", h32.loadDATA, 0);
        @(negedge clk);
        chk("read_then_load", h32.loadDATA, 1);
        h32.newDATA = 1'b0;
        finish32(exp32(bx2, by2, 1'b1), tg2, 32, "reload");

        // newKEY and newDATA together in READY: key wins, block follows expansion
        kr = {$urandom(), $urandom()};
        r  = $urandom();
        bx = r[31:16]; by = r[15:0]; tg = 8'h42;
        @(negedge clk);
        h32.newKEY  = 1'b1;
        h32.KEY     = kr;
        cur_key     = kr;
        h32.newDATA = 1'b1;
        h32.inDATA  = {bx, by};
        h32.decrypt = 1'b0;
        h32.infoIN  = tg;
        @(negedge clk);
        chk("both_loadKEY", h32.loadKEY, 1);
        chk("both_no_loadDATA", h32.loadDATA, 0);
        h32.newKEY = 1'b0;
        seen = 0;
        c = 0;
        while (!h32.doneKEY && c < 100) begin @(negedge clk); c++; seen |= h32.loadDATA; end
        chk("both_kexp", c, 28);
        chk("both_no_load_kexp", seen, 0);
        @(negedge clk);
        chk("both_loadDATA", h32.loadDATA, 1);
        h32.newDATA = 1'b0;
        finish32(exp32(bx, by, 1'b0), tg, 32, "both");

        // Reset at round 10 aborts; blocks refused until a new key expands
        r = $urandom();
        start32(r[31:16], r[15:0], 1'b0, 8'he1);
        repeat (10) @(negedge clk);
        chk("round10_idx", h32.countOUT, 10);
        #2 nR = 1'b0;
        #1;
        chk("arst_flags", {h32.loadKEY, h32.loadDATA, h32.doneKEY, h32.doneDATA}, 0);
        chk("arst_out", out32(), 0);
        chk("arst_tag_cnt", {h32.infoOUT, h32.countOUT}, 0);
        @(negedge clk);
        nR = 1'b1;
        h32.newDATA = 1'b1;
        seen = 0;
        repeat (40) begin @(negedge clk); seen |= h32.loadDATA; end
        h32.newDATA = 1'b0;
        chk("post_rst_no_load", seen, 0);
        chk("post_rst_doneKEY", h32.doneKEY, 0);
        key32({16'h1918, 16'h1110, 16'h0908, 16'h0100});
        start32(16'h6565, 16'h6877, 1'b0, 8'h5e);
        finish32({64'h000000000000c69b, 64'h000000000000e9bb}, 8'h5e, 32, "recover");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
